// File: rtl/aes_arb_pkg.sv
// Shared types for the AES core arbiter: FSM states and the registered response.
package aes_arb_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int ID_MAX_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // id is sized for the largest supported requester count and truncated at the port
  typedef struct packed {
    logic [AES_BLOCK_W-1:0] data;
    logic [ID_MAX_W-1:0]    id;
    logic                   err;
  } arb_rsp_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);
  logic [ID_W-1:0] w_j;

  always_comb begin
    o_idx = '0;
    w_j   = '0;
    // scan farthest offset first so the nearest request overwrites it
    for (int k = N - 1; k >= 0; k--) begin
      w_j = ID_W'((int'(i_ptr) + k) % N);
      if (i_req[w_j]) o_idx = w_j;
    end
    o_any   = |i_req;
    o_grant = '0;
    if (o_any) o_grant[o_idx] = 1'b1;
  end
endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin front end sharing one iterative AES-128 core among N_REQ requesters,
// with a per-transaction timeout that returns an error response.
module aes_core_arbiter
  import aes_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ID_W           = $clog2(N_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ-1:0][AES_BLOCK_W-1:0]   req_plaintext,
  input  logic [N_REQ-1:0][AES_BLOCK_W-1:0]   req_key,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [AES_BLOCK_W-1:0]              rsp_data,
  output logic [ID_W-1:0]                     rsp_id,
  output logic                                rsp_err,
  output logic                                core_start,
  output logic [AES_BLOCK_W-1:0]              core_plaintext,
  output logic [AES_BLOCK_W-1:0]              core_key,
  input  logic [AES_BLOCK_W-1:0]              core_ciphertext,
  input  logic                                core_valid
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t             r_state;
  logic [ID_W-1:0]        r_ptr;
  logic [CNT_W-1:0]       r_cnt;
  logic [AES_BLOCK_W-1:0] r_pt;
  logic [AES_BLOCK_W-1:0] r_key;
  arb_rsp_t               r_rsp;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic [ID_W-1:0]  w_ptr_nxt;

  rr_picker #(.N(N_REQ), .ID_W(ID_W)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_ptr_nxt = ID_W'((int'(r_rsp.id) + 1) % N_REQ);

  // req_ready is the only combinational output; held low while reset is applied
  assign req_ready      = (r_state == IDLE && rst) ? w_grant : '0;
  assign core_start     = (r_state == ISSUE);
  assign rsp_valid      = (r_state == RESP);
  assign rsp_data       = r_rsp.data;
  assign rsp_id         = ID_W'(r_rsp.id);
  assign rsp_err        = r_rsp.err;
  assign core_plaintext = r_pt;
  assign core_key       = r_key;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_pt    <= '0;
      r_key   <= '0;
      r_rsp   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_pt     <= req_plaintext[w_idx];
          r_key    <= req_key[w_idx];
          r_rsp.id <= ID_MAX_W'(w_idx);
          r_state  <= ISSUE;
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // a result arriving on the last timeout cycle still wins
          if (core_valid) begin
            r_rsp.data <= core_ciphertext;
            r_rsp.err  <= 1'b0;
            r_state    <= RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp.data <= '0;
            r_rsp.err  <= 1'b1;
            r_state    <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          r_ptr   <= w_ptr_nxt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a behavioural core: AES-128, XOR stub or silent.
module tb_aes_core_arbiter;
  localparam int LAT = 12;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [3:0]         req_valid = '0;
  logic [3:0]         req_ready;
  logic [3:0][127:0]  req_plaintext = '0;
  logic [3:0][127:0]  req_key = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [127:0]       rsp_data;
  logic [1:0]         rsp_id;
  logic               rsp_err;
  logic               core_start;
  logic [127:0]       core_plaintext, core_key, core_ciphertext;
  logic               core_valid;

  int checks = 0, errors = 0;
  int core_mode = 0;             // 0 AES, 1 plaintext^key, 2 never answers
  logic sp_valid = 1'b0;         // bench-injected core_valid
  logic [127:0] sp_ct = '0;
  logic [127:0] m_ct = '0;
  logic m_valid = 1'b0;
  int m_cd = 0;
  int n_start = 0;
  logic [127:0] tpt [4];
  logic [127:0] tkey [4];

  aes_core_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_plaintext(req_plaintext), .req_key(req_key), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .core_start(core_start), .core_plaintext(core_plaintext), .core_key(core_key),
    .core_ciphertext(core_ciphertext), .core_valid(core_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gm(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb(tmp[31:24]), sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0])} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sb(s[b]);
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[q+4*c] = t[q+4*((c+q)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int b = 0; b < 16; b++) s[b] ^= w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // core model: result appears LAT cycles after the start pulse; reset shares rst
  always @(posedge clk) begin
    if (core_start) n_start <= n_start + 1;
    if (!rst) begin
      m_cd <= 0; m_valid <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (core_start) begin
        m_cd <= (core_mode == 2) ? 0 : LAT - 1;
        m_ct <= (core_mode == 0) ? aes128(core_plaintext, core_key) : (core_plaintext ^ core_key);
      end else if (m_cd != 0) begin
        m_cd <= m_cd - 1;
        if (m_cd == 1) m_valid <= 1'b1;
      end
    end
  end

  assign core_valid      = m_valid | sp_valid;
  assign core_ciphertext = sp_valid ? sp_ct : m_ct;

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b0; sp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_rsp(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (core_start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 4'hF;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready got %h exp 0", req_ready); end
    checks++; if ({rsp_valid, rsp_err, core_start} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {rsp_valid, rsp_err, core_start}); end
    checks++; if (rsp_data !== '0 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp got %h/%0d exp 0/0", rsp_data, rsp_id); end
    checks++; if (core_plaintext !== '0 || core_key !== '0) begin errors++; $display("FAIL reset_core_ops got %h/%h exp 0/0", core_plaintext, core_key); end
    req_valid = '0; rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_aes();
    bit ok; int s0;
    core_mode = 0; s0 = n_start;
    req_plaintext[2] = 128'h00112233445566778899aabbccddeeff;
    req_key[2]       = 128'h000102030405060708090a0b0c0d0e0f;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL single_issue got %b exp 1", core_start); end
    checks++; if (core_plaintext !== 128'h00112233445566778899aabbccddeeff || core_key !== 128'h000102030405060708090a0b0c0d0e0f) begin
      errors++; $display("FAIL single_latch got %h/%h", core_plaintext, core_key); end
    wait_rsp(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_rsp_timeout got none exp rsp_valid"); end
    checks++; if (rsp_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin errors++; $display("FAIL single_data got %h exp 69c4e0d86a7b0430d8cdb78070b4c55a", rsp_data); end
    checks++; if (rsp_id !== 2'd2 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_id_err got %0d/%b exp 2/0", rsp_id, rsp_err); end
    checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL single_starts got %0d exp 1", n_start - s0); end
    handshake();
  endtask

  task automatic test_fairness();
    bit ok; int e;
    do_reset();
    core_mode = 1;
    for (int i = 0; i < 4; i++) begin req_plaintext[i] = tpt[i]; req_key[i] = tkey[i]; end
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      e = t % 4;
      wait_rsp(60, ok);
      checks++; if (!ok || rsp_id !== 2'(e)) begin errors++; $display("FAIL fair_id[%0d] got %0d exp %0d", t, rsp_id, e); end
      checks++; if (rsp_data !== (tpt[e] ^ tkey[e]) || rsp_err !== 1'b0) begin errors++; $display("FAIL fair_data[%0d] got %h exp %h", t, rsp_data, tpt[e] ^ tkey[e]); end
    end
    @(negedge clk);
    req_valid = '0; rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    core_mode = 1;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'hF;
    wait_rsp(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_rsp_timeout got none exp rsp_valid"); end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== (tpt[1] ^ tkey[1]) || rsp_err !== 1'b0 || req_ready !== 4'h0) begin
        errors++; $display("FAIL bp_hold[%0d] got v%b id%0d %h rdy%b exp v1 id1 %h rdy0000", i, rsp_valid, rsp_id, rsp_data, req_ready, tpt[1] ^ tkey[1]);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_complete got %b exp 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next_ptr got %b exp 0100", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    bit ok; int n;
    core_mode = 2;
    req_valid = 4'b0001;
    wait_start(ok);
    req_valid = '0;
    checks++; if (!ok) begin errors++; $display("FAIL to_start got none exp core_start"); end
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); n++;
      if (rsp_valid) break;
    end
    checks++; if (n !== 65) begin errors++; $display("FAIL to_latency got %0d exp 65", n); end
    checks++; if (rsp_err !== 1'b1 || rsp_data !== '0 || rsp_id !== 2'd0) begin errors++; $display("FAIL to_rsp got err%b %h id%0d exp err1 0 id0", rsp_err, rsp_data, rsp_id); end
    handshake();
    core_mode = 1;
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    wait_rsp(60, ok);
    checks++; if (!ok || rsp_data !== (tpt[3] ^ tkey[3]) || rsp_id !== 2'd3 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL to_recover got %h id%0d err%b exp %h id3 err0", rsp_data, rsp_id, rsp_err, tpt[3] ^ tkey[3]); end
    handshake();
  endtask

  task automatic test_spurious();
    bit ok; int n;
    sp_ct = 128'hdeadbeefdeadbeefdeadbeefdeadbeef; sp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || core_start !== 1'b0) begin errors++; $display("FAIL sp_idle[%0d] got v%b s%b exp 0 0", i, rsp_valid, core_start); end
    end
    sp_valid = 1'b0;
    core_mode = 1;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    wait_rsp(60, ok);
    sp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (!ok || rsp_valid !== 1'b1 || rsp_data !== (tpt[1] ^ tkey[1]) || rsp_err !== 1'b0) begin
        errors++; $display("FAIL sp_resp[%0d] got %h exp %h", i, rsp_data, tpt[1] ^ tkey[1]); end
      @(negedge clk);
    end
    sp_valid = 1'b0;
    handshake();
    // result lands on the final timeout cycle
    core_mode = 2; sp_ct = 128'hc0ffee00112233445566778899aabbcc;
    req_valid = 4'b0100;
    wait_start(ok);
    req_valid = '0;
    n = 0;
    for (int i = 0; i < 64; i++) begin @(negedge clk); n++; if (rsp_valid) break; end
    checks++; if (!ok || rsp_valid !== 1'b0 || n !== 64) begin errors++; $display("FAIL sp_edge_early got v%b n%0d exp v0 n64", rsp_valid, n); end
    sp_valid = 1'b1;
    @(negedge clk);
    sp_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 128'hc0ffee00112233445566778899aabbcc || rsp_id !== 2'd2) begin
      errors++; $display("FAIL sp_edge_rsp got v%b err%b %h id%0d exp v1 err0 c0ffee00112233445566778899aabbcc id2", rsp_valid, rsp_err, rsp_data, rsp_id); end
    handshake();
  endtask

  task automatic test_reset_mid();
    bit ok; bit quiet;
    core_mode = 1;
    req_valid = 4'b0010;
    wait_start(ok);
    req_valid = '0;
    checks++; if (!ok) begin errors++; $display("FAIL rm_start got none exp core_start"); end
    repeat (3) @(negedge clk);
    rst = 1'b0; req_valid = 4'hF;
    @(negedge clk);
    checks++; if (req_ready !== 4'h0 || {rsp_valid, rsp_err, core_start} !== 3'b000 || rsp_data !== '0 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL rm_outputs got rdy%b v%b e%b s%b %h id%0d exp all 0", req_ready, rsp_valid, rsp_err, core_start, rsp_data, rsp_id); end
    checks++; if (core_plaintext !== '0 || core_key !== '0) begin errors++; $display("FAIL rm_core_ops got %h/%h exp 0/0", core_plaintext, core_key); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr got %b exp 0001", req_ready); end
    req_valid = '0;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || core_start !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rm_no_rsp got activity exp none"); end
    req_valid = 4'hF;
    @(negedge clk);
    req_valid = '0;
    wait_rsp(60, ok);
    checks++; if (!ok || rsp_id !== 2'd0 || rsp_data !== (tpt[0] ^ tkey[0])) begin
      errors++; $display("FAIL rm_first got id%0d %h exp id0 %h", rsp_id, rsp_data, tpt[0] ^ tkey[0]); end
    handshake();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tpt[0] = 128'h0f0e0d0c0b0a09080706050403020100; tkey[0] = 128'hffffffffffffffff0000000000000000;
    tpt[1] = 128'h11111111222222223333333344444444; tkey[1] = 128'h0123456789abcdef0123456789abcdef;
    tpt[2] = 128'hdeadbeefdeadbeefdeadbeefdeadbeef; tkey[2] = 128'hdeadbeef00000000deadbeef00000000;
    tpt[3] = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5; tkey[3] = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
    test_reset();
    test_single_aes();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
